// File: rtl/alu_div_unit.sv
// alu_div_unit: multi-cycle radix-2 restoring divider for the DIV/MOD ALU codes.
// It produces one quotient bit per clock. Divide-by-zero and signed overflow finish
// in a single cycle. The result is returned through a start/busy/done handshake.
module alu_div_unit #(
   parameter int DIVw = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            divStart,
   input  logic            divSigned,
   input  logic            divMod,
   input  logic [DIVw-1:0] inDIVa,
   input  logic [DIVw-1:0] inDIVb,
   output logic            divBusy,
   output logic            divDone,
   output logic [DIVw-1:0] outDIV
);

   localparam int CW = $clog2(DIVw + 1);
   localparam logic [DIVw-1:0] MINV = {1'b1, {(DIVw-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DIVw-1:0] rem_q, rem_d;
   logic [DIVw-1:0] quo_q, quo_d;
   logic [DIVw-1:0] bmag_q, bmag_d;
   logic [DIVw-1:0] out_q, out_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;
   logic            mod_q, mod_d;

   logic            div0, ovf;
   logic [DIVw:0]   shifted, trial;
   logic [DIVw-1:0] rem_nx, quo_nx;

   // Magnitude of an operand. The most-negative value maps to itself, read as unsigned.
   function automatic logic [DIVw-1:0] mag(input logic [DIVw-1:0] v, input logic s);
      return (s && v[DIVw-1]) ? (~v + 1'b1) : v;
   endfunction

   // Conditional two's-complement negation for the final sign fix.
   function automatic logic [DIVw-1:0] fix(input logic [DIVw-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   // Next-state, datapath step and result selection
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      bmag_d  = bmag_q;
      out_d   = out_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      mod_d   = mod_q;

      div0 = (inDIVb == '0);
      ovf  = divSigned && (inDIVa == MINV) && (inDIVb == '1);

      // One restoring step. The partial remainder stays below |b|, so the shifted
      // value fits in DIVw+1 bits and the trial's top bit is a true sign.
      shifted = {rem_q, quo_q[DIVw-1]};
      trial   = shifted - {1'b0, bmag_q};
      rem_nx  = trial[DIVw] ? shifted[DIVw-1:0] : trial[DIVw-1:0];
      quo_nx  = {quo_q[DIVw-2:0], ~trial[DIVw]};

      case (state_q)
         S_IDLE: begin
            if (divStart) begin
               mod_d = divMod;
               if (div0 || ovf) begin
                  if (div0) out_d = divMod ? inDIVa : '1;
                  else      out_d = divMod ? '0 : MINV;
                  state_d = S_DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = mag(inDIVa, divSigned);
                  bmag_d  = mag(inDIVb, divSigned);
                  negq_d  = divSigned && (inDIVa[DIVw-1] ^ inDIVb[DIVw-1]);
                  negr_d  = divSigned && inDIVa[DIVw-1];
                  cnt_d   = CW'(DIVw);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               out_d   = mod_q ? fix(rem_nx, negr_q) : fix(quo_nx, negq_q);
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         bmag_q  <= '0;
         out_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         mod_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         bmag_q  <= bmag_d;
         out_q   <= out_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         mod_q   <= mod_d;
      end
   end

   assign divBusy = (state_q != S_IDLE);
   assign divDone = (state_q == S_DONE);
   assign outDIV  = out_q;

endmodule

// File: tb/tb_alu_div_unit.sv
// Testbench for alu_div_unit: directed cases followed by a randomized run,
// checked against an arithmetic reference model.
module tb_alu_div_unit;

   localparam int W = 32;
   localparam logic [W-1:0] MINV = 32'h8000_0000;
   localparam logic [W-1:0] MAXV = 32'h7FFF_FFFF;

   logic         clk = 1'b0;
   logic         rst;
   logic         divStart, divSigned, divMod;
   logic [W-1:0] inDIVa, inDIVb;
   logic         divBusy, divDone;
   logic [W-1:0] outDIV;

   int ncmp = 0;
   int nerr = 0;

   alu_div_unit #(.DIVw(W)) dut (
      .clk(clk), .rst(rst), .divStart(divStart), .divSigned(divSigned),
      .divMod(divMod), .inDIVa(inDIVa), .inDIVb(inDIVb),
      .divBusy(divBusy), .divDone(divDone), .outDIV(outDIV)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: truncating division in wide signed arithmetic, plus the two special rules.
   function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s, input logic m);
      longint sa, sb, q, r;
      if (b == '0) return m ? a : '1;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return m ? r[W-1:0] : q[W-1:0];
   endfunction

   function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      return (b == '0 || (s && a == MINV && b == '1)) ? 1 : W + 1;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 9))
         0: return '0;
         1: return 32'd1;
         2: return '1;
         3: return MINV;
         4: return MAXV;
         5: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // One operation: start, track latency, check busy/done/result, and optionally
   // pulse an ignored divStart at cycle 'poke'.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic m, input int poke,
                         output logic [W-1:0] res);
      int lat;
      lat = -1;
      @(negedge clk);
      inDIVa = a; inDIVb = b; divSigned = s; divMod = m; divStart = 1'b1;
      @(posedge clk);
      #1;
      divStart = 1'b0;
      inDIVa = $urandom; inDIVb = $urandom; divSigned = 1'($urandom); divMod = 1'($urandom);
      for (int k = 1; k <= W + 8; k++) begin
         @(negedge clk);
         if (k == 1) check({tag, " busy"}, W'(divBusy), W'(1));
         if (poke != 0 && k == poke) begin
            divStart = 1'b1; inDIVa = $urandom; inDIVb = 32'd3;
         end else begin
            divStart = 1'b0;
         end
         if (divDone) begin
            lat = k;
            break;
         end
      end
      divStart = 1'b0;
      check({tag, " latency"}, W'(lat), W'(ref_lat(a, b, s)));
      res = outDIV;
      check({tag, " result"}, outDIV, ref_div(a, b, s, m));
      @(negedge clk);
      check({tag, " done width"}, W'(divDone), W'(0));
      check({tag, " idle"}, W'(divBusy), W'(0));
      check({tag, " hold"}, outDIV, res);
   endtask

   initial begin
      logic [W-1:0] r, q, rm, a, b, ma, mr, mb;
      logic s;
      int seen;
      rst = 1'b1; divStart = 1'b0; divSigned = 1'b0; divMod = 1'b0;
      inDIVa = '0; inDIVb = '0;
      repeat (2) @(negedge clk);
      check("reset busy", W'(divBusy), W'(0));
      check("reset done", W'(divDone), W'(0));
      check("reset out", outDIV, W'(0));
      rst = 1'b0;

      run_op("u100/7 q", 32'd100, 32'd7, 1'b0, 1'b0, 0, r);
      check("u100/7 q value", r, 32'd14);
      run_op("u100/7 r", 32'd100, 32'd7, 1'b0, 1'b1, 0, r);
      check("u100/7 r value", r, 32'd2);
      run_op("s-7/2 q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0, r);
      check("s-7/2 q value", r, 32'hFFFF_FFFD);
      run_op("s-7/2 r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0, r);
      check("s-7/2 r value", r, 32'hFFFF_FFFF);
      run_op("s7/-2 q", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, r);
      check("s7/-2 q value", r, 32'hFFFF_FFFD);
      run_op("s7/-2 r", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 0, r);
      check("s7/-2 r value", r, 32'd1);
      for (int sm = 0; sm < 2; sm++) begin
         run_op("div0 q", 32'd5, 32'd0, 1'(sm), 1'b0, 0, r);
         check("div0 q value", r, 32'hFFFF_FFFF);
         run_op("div0 r", 32'd5, 32'd0, 1'(sm), 1'b1, 0, r);
         check("div0 r value", r, 32'd5);
      end
      run_op("ovf q", MINV, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, r);
      check("ovf q value", r, MINV);
      run_op("ovf r", MINV, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, r);
      check("ovf r value", r, 32'd0);
      run_op("uMIN/FF q", MINV, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, r);
      check("uMIN/FF q value", r, 32'd0);
      run_op("uMIN/FF r", MINV, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, r);
      check("uMIN/FF r value", r, MINV);

      // Asynchronous reset in the middle of an operation
      @(negedge clk);
      inDIVa = 32'd100; inDIVb = 32'd7; divSigned = 1'b0; divMod = 1'b0; divStart = 1'b1;
      @(posedge clk);
      #1 divStart = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort busy", W'(divBusy), W'(0));
      check("abort out", outDIV, W'(0));
      check("abort done", W'(divDone), W'(0));
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < W + 8; k++) begin
         @(negedge clk);
         if (divDone) seen++;
      end
      check("abort no done", W'(seen), W'(0));

      run_op("ignored start", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 5, r);
      check("ignored start value", r, 32'hFFFF_FFFF);

      // Randomized pairs: quotient and remainder of the same operands, plus identity
      for (int n = 0; n < 800; n++) begin
         a = pick(); b = pick(); s = 1'($urandom);
         run_op("rand q", a, b, s, 1'b0, 0, q);
         run_op("rand r", a, b, s, 1'b1, 0, rm);
         if (b != '0) begin
            check("rand identity", q * b + rm, a);
            mr = (s && rm[W-1]) ? -rm : rm;
            mb = (s && b[W-1]) ? -b : b;
            check("rand |r|<|b|", W'(mr < mb), W'(1));
            ma = a;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
